// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: latency-configurable data memory with req/done handshake,
// byte-lane writes, registered read data and out-of-range detection.
module data_mem_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int NB = DATA_WIDTH / 8;
    // One extra bit so DEPTH == 2^ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

    state_t                  r_state, w_next;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [NB-1:0]           r_be;
    logic [3:0]              r_cnt;
    logic                    r_done, r_err;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic                    w_accept, w_access, w_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = req ? (WAIT_STATES > 0 ? S_WAIT : S_ACCESS) : S_IDLE;
            S_WAIT:   w_next = (r_cnt == 4'd1) ? S_ACCESS : S_WAIT;
            S_ACCESS: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = r_state != S_IDLE;
        w_accept   = r_state == S_IDLE && req;
        w_access   = r_state == S_ACCESS;
        w_in_range = {1'b0, r_addr} < DEPTH_W;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_done <= w_access;
            r_err  <= w_access && !w_in_range;
            if (w_accept) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_be    <= be;
                r_cnt   <= 4'(WAIT_STATES);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access && !r_we)
                r_rdata <= w_in_range ? r_mem[r_addr] : '0;
        end
    end

    // Array is deliberately not reset; an async reset forces IDLE so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (w_access && r_we && w_in_range)
            for (int i = 0; i < NB; i++)
                if (r_be[i]) r_mem[r_addr][i*8 +: 8] <= r_wdata[i*8 +: 8];
    end

    assign done  = r_done;
    assign err   = r_err;
    assign rdata = r_rdata;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks over three configurations (defaults,
// 16-bit/3-wait/200-deep, 2-wait with its own reset for the abort case).
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, rst_n2;
    logic [2:0]  req, we, busy, done, err;
    logic [7:0]  addr  [3];
    logic [15:0] wdata [3];
    logic [1:0]  be    [3];
    logic [7:0]  rd0, rd2;
    logic [15:0] rd1;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    data_mem_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0][7:0]), .be(be[0][0:0]), .busy(busy[0]), .done(done[0]),
        .err(err[0]), .rdata(rd0)
    );

    data_mem_ctrl #(.DATA_WIDTH(16), .DEPTH(200), .WAIT_STATES(3)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .be(be[1]), .busy(busy[1]), .done(done[1]),
        .err(err[1]), .rdata(rd1)
    );

    data_mem_ctrl #(.WAIT_STATES(2)) u2 (
        .clk(clk), .rst_n(rst_n2), .req(req[2]), .we(we[2]), .addr(addr[2]),
        .wdata(wdata[2][7:0]), .be(be[2][0:0]), .busy(busy[2]), .done(done[2]),
        .err(err[2]), .rdata(rd2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one access at the current negedge, toggle junk requests while busy,
    // and return at the negedge of the done cycle.
    task automatic acc(input int d, input logic w, input logic [7:0] a,
                       input logic [15:0] wd, input logic [1:0] b);
        int ws;
        ws = (d == 1) ? 3 : (d == 2) ? 2 : 0;
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
        for (int k = 1; k <= ws + 1; k++) begin
            @(negedge clk);
            chk($sformatf("d%0d_busy_c%0d", d, k), 32'(busy[d]), 32'd1);
            chk($sformatf("d%0d_nodone_c%0d", d, k), 32'(done[d]), 32'd0);
            req[d] = (k <= ws) ? k[0] : 1'b0;
            we[d] = 1'b1; wdata[d] = 16'hFFFF; be[d] = 2'b11;
        end
        @(negedge clk);
        chk($sformatf("d%0d_done", d), 32'(done[d]), 32'd1);
        chk($sformatf("d%0d_idle", d), 32'(busy[d]), 32'd0);
        we[d] = 1'b0; be[d] = 2'b00;
    endtask

    initial begin
        req = '0; we = '0;
        for (int i = 0; i < 3; i++) begin addr[i] = '0; wdata[i] = '0; be[i] = '0; end
        rst_n = 1'b0; rst_n2 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; rst_n2 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd0", 32'(rd0), 32'd0);
        chk("rst_rd1", 32'(rd1), 32'd0);
        chk("rst_rd2", 32'(rd2), 32'd0);

        acc(0, 1'b1, 8'h10, 16'h00A5, 2'b01);
        chk("d0_wr_err", 32'(err[0]), 32'd0);
        acc(0, 1'b0, 8'h10, 16'h0000, 2'b00);
        chk("d0_rd_data", 32'(rd0), 32'hA5);
        chk("d0_rd_err", 32'(err[0]), 32'd0);
        @(negedge clk);
        chk("d0_done_pulse", 32'(done[0]), 32'd0);
        chk("d0_rd_hold", 32'(rd0), 32'hA5);

        acc(1, 1'b1, 8'd5, 16'h1234, 2'b11);
        acc(1, 1'b1, 8'd5, 16'hABCD, 2'b01);
        acc(1, 1'b0, 8'd5, 16'h0000, 2'b00);
        chk("d1_be_merge", 32'(rd1), 32'h12CD);
        chk("d1_be_err", 32'(err[1]), 32'd0);
        acc(1, 1'b1, 8'd210, 16'h00FF, 2'b11);
        chk("d1_oor_wr_err", 32'(err[1]), 32'd1);
        chk("d1_wr_keeps_rd", 32'(rd1), 32'h12CD);
        @(negedge clk);
        chk("d1_err_pulse", 32'(err[1]), 32'd0);
        chk("d1_done_pulse", 32'(done[1]), 32'd0);
        acc(1, 1'b0, 8'd210, 16'h0000, 2'b00);
        chk("d1_oor_rd_err", 32'(err[1]), 32'd1);
        chk("d1_oor_rd_data", 32'(rd1), 32'h0000);
        acc(1, 1'b1, 8'd199, 16'h5A5A, 2'b11);
        chk("d1_edge_wr_err", 32'(err[1]), 32'd0);
        acc(1, 1'b0, 8'd199, 16'h0000, 2'b00);
        chk("d1_edge_rd_err", 32'(err[1]), 32'd0);
        chk("d1_edge_rd_data", 32'(rd1), 32'h5A5A);

        acc(2, 1'b1, 8'd3, 16'h0011, 2'b01);
        acc(2, 1'b0, 8'd3, 16'h0000, 2'b00);
        chk("d2_pre_data", 32'(rd2), 32'h11);
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 8'd3; wdata[2] = 16'h0077; be[2] = 2'b01;
        @(negedge clk);
        req[2] = 1'b0;
        chk("d2_wait_busy", 32'(busy[2]), 32'd1);
        #2 rst_n2 = 1'b0;
        #1;
        chk("d2_abort_busy", 32'(busy[2]), 32'd0);
        chk("d2_abort_rd", 32'(rd2), 32'd0);
        repeat (3) @(negedge clk);
        chk("d2_abort_nodone", 32'(done[2]), 32'd0);
        rst_n2 = 1'b1;
        @(negedge clk);
        chk("d2_post_idle", 32'(busy[2]), 32'd0);
        acc(2, 1'b0, 8'd3, 16'h0000, 2'b00);
        chk("d2_abort_nowrite", 32'(rd2), 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
